// File: rtl/aes_128_key_expand_wr.sv
// AES-128 key expansion feeding the round-key RAM: computes round keys 0..ROUNDS
// on the fly and streams them as 2*(ROUNDS+1) back-to-back 64-bit write beats.
module aes_128_key_expand_wr #(
  parameter int unsigned ROUNDS    = 10,
  parameter logic [7:0]  RCON_INIT = 8'h01
) (
  input  logic         clk,
  input  logic         kill,
  input  logic [127:0] key_in,
  input  logic         key_start,
  output logic         key_busy,
  output logic         key_done,
  input  logic         wr_idle,
  output logic         en_wr,
  output logic [63:0]  key_round_wr
);

  localparam int unsigned CW = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] LAST_RND = CW'(ROUNDS);
  localparam logic [CW-1:0] RND_ONE  = CW'(1);
  localparam logic [CW-1:0] RND_ZERO = CW'(0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_LO   = 3'd2,
    S_HI   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_e         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [CW-1:0]  rnd_q, rnd_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           en_wr_q, en_wr_d;
  logic [63:0]    wr_q, wr_d;

  // Next-state and registered-output decode for the burst sequencer.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    rnd_d   = rnd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    en_wr_d = 1'b0;
    wr_d    = 64'h0;
    case (state_q)
      S_IDLE: begin
        if (key_start) begin
          key_d   = key_in;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // wr_idle matters only here; once the burst starts it runs to the end.
        if (wr_idle) begin
          en_wr_d = 1'b1;
          wr_d    = key_q[127:64];
          state_d = S_LO;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_LO: begin
        en_wr_d = 1'b1;
        wr_d    = key_q[63:0];
        key_d   = next_key(key_q, rcon_q);
        rcon_d  = xtime(rcon_q);
        rnd_d   = rnd_q + RND_ONE;
        if (rnd_q < LAST_RND) begin
          state_d = S_HI;
        end else begin
          state_d = S_DONE;
        end
      end
      S_HI: begin
        en_wr_d = 1'b1;
        wr_d    = key_q[127:64];
        state_d = S_LO;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        rnd_d   = RND_ZERO;
        rcon_d  = RCON_INIT;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        rnd_d   = RND_ZERO;
        rcon_d  = RCON_INIT;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; kill wins over every other input.
  always_ff @(posedge clk) begin
    if (kill) begin
      state_q <= S_IDLE;
      key_q   <= 128'h0;
      rcon_q  <= RCON_INIT;
      rnd_q   <= RND_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_wr_q <= 1'b0;
      wr_q    <= 64'h0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      rnd_q   <= rnd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_wr_q <= en_wr_d;
      wr_q    <= wr_d;
    end
  end

  assign key_busy     = busy_q;
  assign key_done     = done_q;
  assign en_wr        = en_wr_q;
  assign key_round_wr = wr_q;

endmodule

// File: tb/tb_aes_128_key_expand_wr.sv
// Directed bench for aes_128_key_expand_wr: an independent key-schedule model
// (S-box derived from GF(2^8) inversion) fills a beat scoreboard per accepted key.
module tb_aes_128_key_expand_wr;

  logic         clk = 1'b0;
  logic         kill = 1'b1;
  logic [127:0] key_in = 128'h0;
  logic         key_start = 1'b0;
  logic         key_busy;
  logic         key_done;
  logic         wr_idle = 1'b1;
  logic         en_wr;
  logic [63:0]  key_round_wr;

  aes_128_key_expand_wr dut (
    .clk          (clk),
    .kill         (kill),
    .key_in       (key_in),
    .key_start    (key_start),
    .key_busy     (key_busy),
    .key_done     (key_done),
    .wr_idle      (wr_idle),
    .en_wr        (en_wr),
    .key_round_wr (key_round_wr)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cap [22];
  logic [7:0]  sb [256];
  logic [7:0]  rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int i = 0; i < 256; i++) begin
      x   = 8'(i);
      inv = 8'h01;
      if (i == 0) inv = 8'h00;
      else for (int j = 0; j < 254; j++) inv = gmul(inv, x);
      sb[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic push_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon_tab[i/4-1], 24'h000000};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      exp_q.push_back({w[4*r], w[4*r+1]});
      exp_q.push_back({w[4*r+2], w[4*r+3]});
    end
  endtask

  task automatic start_key(input string tag, input logic [127:0] k);
    key_in    = k;
    key_start = 1'b1;
    push_model(k);
    step();
    key_start = 1'b0;
    chk({tag, "_busy_on_accept"}, 64'(key_busy), 64'h1);
    chk({tag, "_no_wr_on_accept"}, 64'(en_wr), 64'h0);
  endtask

  // Runs one burst to key_done; optionally pokes key_start (key_in=0) or drops wr_idle mid-burst.
  task automatic drain(input string tag, input int first_c, input int poke_at, input int drop_at);
    int beats, first_seen, done_c, last_c;
    bit gap;
    beats = 0; first_seen = -1; done_c = -1; last_c = -1; gap = 1'b0;
    for (int c = 1; c <= 60 && done_c < 0; c++) begin
      step();
      if (en_wr) begin
        if (beats > 0 && last_c != c - 1) gap = 1'b1;
        if (first_seen < 0) first_seen = c;
        if (beats < 22) cap[beats] = key_round_wr;
        if (exp_q.size() > 0) chk($sformatf("%s_beat%0d", tag, beats + 1), key_round_wr, exp_q.pop_front());
        chk($sformatf("%s_busy_beat%0d", tag, beats + 1), 64'(key_busy), 64'h1);
        beats++;
        last_c = c;
      end
      if (key_done) done_c = c;
      if (c == poke_at) begin
        key_in    = 128'h0;
        key_start = 1'b1;
      end else begin
        key_start = 1'b0;
      end
      if (c == drop_at) wr_idle = 1'b0;
    end
    key_start = 1'b0;
    chk({tag, "_first_beat_cycle"}, 64'(first_seen), 64'(first_c));
    chk({tag, "_beat_count"}, 64'(beats), 64'd22);
    chk({tag, "_gapless"}, 64'(gap), 64'h0);
    chk({tag, "_done_cycle"}, 64'(done_c), 64'(first_c + 22));
    chk({tag, "_busy_at_done"}, 64'(key_busy), 64'h0);
    chk({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'h0);
  endtask

  initial begin
    build_sbox();

    // Reset with key_start held high.
    kill = 1'b1; key_start = 1'b1; key_in = FIPS_KEY; wr_idle = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_en_wr", 64'(en_wr), 64'h0);
      chk("rst_busy", 64'(key_busy), 64'h0);
      chk("rst_done", 64'(key_done), 64'h0);
      chk("rst_wr_data", key_round_wr, 64'h0);
    end
    kill = 1'b0; key_start = 1'b0;
    step();
    chk("post_rst_busy", 64'(key_busy), 64'h0);

    // FIPS-197 vector, wr_idle high.
    start_key("fips", FIPS_KEY);
    drain("fips", 1, -1, -1);
    chk("fips_b1", cap[0], 64'h2b7e151628aed2a6);
    chk("fips_b2", cap[1], 64'habf7158809cf4f3c);
    chk("fips_b3", cap[2], 64'ha0fafe1788542cb1);
    chk("fips_b4", cap[3], 64'h23a339392a6c7605);
    chk("fips_b21", cap[20], 64'hd014f9a8c9ee2589);
    chk("fips_b22", cap[21], 64'he13f0cc8b6630ca6);
    step();
    chk("fips_done_one_pulse", 64'(key_done), 64'h0);
    chk("fips_idle_en_wr", 64'(en_wr), 64'h0);

    // wr_idle gating, then a drop of wr_idle mid-burst.
    wr_idle = 1'b0;
    start_key("gate", 128'h000102030405060708090a0b0c0d0e0f);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("gate_hold_en_wr", 64'(en_wr), 64'h0);
      chk("gate_hold_busy", 64'(key_busy), 64'h1);
    end
    wr_idle = 1'b1;
    drain("gate", 1, -1, 5);
    wr_idle = 1'b1;
    step();

    // key_start (key_in=0) mid-burst is ignored; back-to-back zero key follows.
    start_key("ign", {$urandom(), $urandom(), $urandom(), $urandom()});
    drain("ign", 1, 8, -1);
    start_key("zero", 128'h0);
    drain("zero", 1, 22, -1);
    chk("zero_b1", cap[0], 64'h0);
    chk("zero_b2", cap[1], 64'h0);
    chk("zero_b3", cap[2], 64'h6263636362636363);
    chk("zero_b4", cap[3], 64'h6263636362636363);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("same_edge_start_busy", 64'(key_busy), 64'h0);
      chk("same_edge_start_en_wr", 64'(en_wr), 64'h0);
    end

    // Kill after beat 7, then a clean restart.
    start_key("kill", FIPS_KEY);
    for (int c = 1; c <= 7; c++) begin
      step();
      chk($sformatf("kill_pre_en%0d", c), 64'(en_wr), 64'h1);
      chk($sformatf("kill_pre_beat%0d", c), key_round_wr, exp_q.pop_front());
    end
    kill = 1'b1;
    step();
    kill = 1'b0;
    exp_q.delete();
    chk("kill_en_wr", 64'(en_wr), 64'h0);
    chk("kill_busy", 64'(key_busy), 64'h0);
    chk("kill_wr_data", key_round_wr, 64'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("kill_quiet_en_wr", 64'(en_wr), 64'h0);
      chk("kill_no_done", 64'(key_done), 64'h0);
    end
    start_key("restart", FIPS_KEY);
    drain("restart", 1, -1, -1);
    chk("restart_b3", cap[2], 64'ha0fafe1788542cb1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
